// File: rtl/xmerge_rr_pkg.sv
// Shared types and helpers for the xmerge_rr write/read merge.
// Holds the per-channel state encoding and the grant-index width rule.
package xmerge_rr_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } ch_state_e;

    // Grant index width, never narrower than one bit so N_SLAVES=1 still has a port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xmerge_rr_ch.sv
// One merge channel: IDLE/BURST FSM, round-robin or fixed-priority arbiter,
// captured burst length, saturating beat counter and sticky length-error bit.
module xmerge_rr_ch
    import xmerge_rr_pkg::*;
#(
    parameter int N_SLAVES = 4,
    parameter int LEN_W    = 8,
    parameter int ARB_RR   = 1,
    parameter int SEL_W    = sel_width(N_SLAVES)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [N_SLAVES-1:0]       req_i,
    input  logic [N_SLAVES-1:0]       valid_i,
    input  logic [LEN_W*N_SLAVES-1:0] len_i,
    input  logic                      ready_i,
    input  logic                      last_i,
    input  logic                      err_clr_i,
    output logic                      busy_o,
    output logic [SEL_W-1:0]          grant_o,
    output logic [N_SLAVES-1:0]       sel_o,
    output logic [LEN_W-1:0]          len_o,
    output logic                      valid_o,
    output logic                      err_o
);

    ch_state_e             state_r;
    ch_state_e             state_s;
    logic [SEL_W-1:0]      grant_r;
    logic [SEL_W-1:0]      ptr_r;
    logic [SEL_W-1:0]      winner_s;
    logic [SEL_W-1:0]      ptr_nx_s;
    logic [LEN_W-1:0]      len_r;
    logic [LEN_W-1:0]      cnt_r;
    logic [LEN_W-1:0]      win_len_s;
    logic [N_SLAVES-1:0]   sel_s;
    logic                  err_r;
    logic                  busy_s;
    logic                  load_s;
    logic                  xfer_s;
    logic                  done_s;

    // Arbiter: fixed priority is the round-robin search anchored at slave 0.
    always_comb begin
        int unsigned idx_v;
        logic        found_v;
        winner_s  = '0;
        win_len_s = '0;
        found_v   = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            idx_v    = (((ARB_RR != 0) ? int'(ptr_r) : 0) + i) % N_SLAVES;
            winner_s = (!found_v && req_i[idx_v]) ? SEL_W'(idx_v) : winner_s;
            found_v  = found_v | req_i[idx_v];
        end
        for (int g = 0; g < N_SLAVES; g++) begin
            win_len_s = (winner_s == SEL_W'(g)) ? len_i[g*LEN_W +: LEN_W] : win_len_s;
        end
        ptr_nx_s = (ARB_RR != 0) ? SEL_W'((int'(winner_s) + 1) % N_SLAVES) : '0;
    end

    // One-hot view of the granted slave, empty outside a burst.
    always_comb begin
        for (int g = 0; g < N_SLAVES; g++) begin
            sel_s[g] = busy_s && (grant_r == SEL_W'(g));
        end
    end

    assign busy_s  = (state_r == ST_BURST);
    assign valid_o = |(sel_s & valid_i);
    assign xfer_s  = valid_o && ready_i;
    assign done_s  = xfer_s && last_i;

    // Next-state logic; master last alone closes a burst.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|req_i) begin
                    state_s = ST_BURST;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BURST;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant capture, pointer advance and saturating beat counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_r <= '0;
            ptr_r   <= '0;
            len_r   <= '0;
            cnt_r   <= '0;
        end else if (load_s) begin
            grant_r <= winner_s;
            ptr_r   <= ptr_nx_s;
            len_r   <= win_len_s;
            cnt_r   <= '0;
        end else if (xfer_s && (cnt_r != {LEN_W{1'b1}})) begin
            cnt_r   <= cnt_r + LEN_W'(1);
        end
    end

    // Sticky mismatch flag; a set in the same cycle as a clear wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_r <= 1'b0;
        end else if (done_s && (cnt_r != len_r)) begin
            err_r <= 1'b1;
        end else if (err_clr_i) begin
            err_r <= 1'b0;
        end
    end

    assign busy_o  = busy_s;
    assign grant_o = busy_s ? grant_r : '0;
    assign len_o   = busy_s ? len_r : '0;
    assign sel_o   = sel_s;
    assign err_o   = err_r;

endmodule

// File: rtl/xmerge_rr.sv
// N-slave to one-master merge with independent write and read channels.
// Classifies requests by strobe, runs one channel engine each and muxes the granted slave.
module xmerge_rr
    import xmerge_rr_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int N_SLAVES = 4,
    parameter int LEN_W    = 8,
    parameter int ARB_RR   = 1,
    localparam int SEL_W   = sel_width(N_SLAVES),
    localparam int STRB_W  = DATA_W / 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [N_SLAVES-1:0]        s_valid_i,
    output logic [N_SLAVES-1:0]        s_ready_o,
    output logic [N_SLAVES-1:0]        s_last_o,
    input  logic [ADDR_W*N_SLAVES-1:0] s_addr_i,
    input  logic [DATA_W*N_SLAVES-1:0] s_wdata_i,
    input  logic [STRB_W*N_SLAVES-1:0] s_wstrb_i,
    input  logic [LEN_W*N_SLAVES-1:0]  s_len_i,
    output logic [DATA_W-1:0]          s_rdata_o,
    output logic                       m_wvalid_o,
    output logic [ADDR_W-1:0]          m_waddr_o,
    output logic [DATA_W-1:0]          m_wdata_o,
    output logic [STRB_W-1:0]          m_wstrb_o,
    output logic [LEN_W-1:0]           m_wlen_o,
    input  logic                       m_wready_i,
    input  logic                       m_wlast_i,
    output logic                       m_rvalid_o,
    output logic [ADDR_W-1:0]          m_raddr_o,
    output logic [LEN_W-1:0]           m_rlen_o,
    input  logic                       m_rready_i,
    input  logic                       m_rlast_i,
    input  logic [DATA_W-1:0]          m_rdata_i,
    output logic                       w_busy_o,
    output logic                       r_busy_o,
    output logic [SEL_W-1:0]           w_grant_o,
    output logic [SEL_W-1:0]           r_grant_o,
    output logic [1:0]                 len_err_o,
    input  logic                       err_clr_i
);

    logic [N_SLAVES-1:0] w_req_s;
    logic [N_SLAVES-1:0] r_req_s;
    logic [N_SLAVES-1:0] w_sel_s;
    logic [N_SLAVES-1:0] r_sel_s;
    logic                w_err_s;
    logic                r_err_s;

    // A zero strobe slice marks a read request.
    always_comb begin
        for (int g = 0; g < N_SLAVES; g++) begin
            w_req_s[g] = s_valid_i[g] && (|s_wstrb_i[g*STRB_W +: STRB_W]);
            r_req_s[g] = s_valid_i[g] && !(|s_wstrb_i[g*STRB_W +: STRB_W]);
        end
    end

    xmerge_rr_ch #(
        .N_SLAVES (N_SLAVES),
        .LEN_W    (LEN_W),
        .ARB_RR   (ARB_RR),
        .SEL_W    (SEL_W)
    ) u_wch (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (w_req_s),
        .valid_i   (s_valid_i),
        .len_i     (s_len_i),
        .ready_i   (m_wready_i),
        .last_i    (m_wlast_i),
        .err_clr_i (err_clr_i),
        .busy_o    (w_busy_o),
        .grant_o   (w_grant_o),
        .sel_o     (w_sel_s),
        .len_o     (m_wlen_o),
        .valid_o   (m_wvalid_o),
        .err_o     (w_err_s)
    );

    xmerge_rr_ch #(
        .N_SLAVES (N_SLAVES),
        .LEN_W    (LEN_W),
        .ARB_RR   (ARB_RR),
        .SEL_W    (SEL_W)
    ) u_rch (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (r_req_s),
        .valid_i   (s_valid_i),
        .len_i     (s_len_i),
        .ready_i   (m_rready_i),
        .last_i    (m_rlast_i),
        .err_clr_i (err_clr_i),
        .busy_o    (r_busy_o),
        .grant_o   (r_grant_o),
        .sel_o     (r_sel_s),
        .len_o     (m_rlen_o),
        .valid_o   (m_rvalid_o),
        .err_o     (r_err_s)
    );

    // AND-OR mux of the granted slave's fields; selects are zero when idle or in reset.
    always_comb begin
        m_waddr_o = '0;
        m_wdata_o = '0;
        m_wstrb_o = '0;
        m_raddr_o = '0;
        for (int g = 0; g < N_SLAVES; g++) begin
            m_waddr_o = m_waddr_o | (s_addr_i[g*ADDR_W +: ADDR_W] & {ADDR_W{w_sel_s[g]}});
            m_wdata_o = m_wdata_o | (s_wdata_i[g*DATA_W +: DATA_W] & {DATA_W{w_sel_s[g]}});
            m_wstrb_o = m_wstrb_o | (s_wstrb_i[g*STRB_W +: STRB_W] & {STRB_W{w_sel_s[g]}});
            m_raddr_o = m_raddr_o | (s_addr_i[g*ADDR_W +: ADDR_W] & {ADDR_W{r_sel_s[g]}});
        end
    end

    assign s_ready_o = (w_sel_s & {N_SLAVES{m_wready_i}}) | (r_sel_s & {N_SLAVES{m_rready_i}});
    assign s_last_o  = (w_sel_s & {N_SLAVES{m_wlast_i}}) | (r_sel_s & {N_SLAVES{m_rlast_i}});
    assign s_rdata_o = m_rdata_i;
    assign len_err_o = {r_err_s, w_err_s};

endmodule

// File: tb/tb_xmerge_rr.sv
// Directed self-checking bench for xmerge_rr with N_SLAVES=4; a second
// fixed-priority instance shares the stimulus for the arbitration-order check.
module tb_xmerge_rr;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int N  = 4;
    localparam int LW = 8;
    localparam int SW = 2;
    localparam int TW = DW / 8;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [N-1:0]    s_valid_i;
    logic [N-1:0]    s_ready_o, fp_s_ready_o;
    logic [N-1:0]    s_last_o, fp_s_last_o;
    logic [AW*N-1:0] s_addr_i;
    logic [DW*N-1:0] s_wdata_i;
    logic [TW*N-1:0] s_wstrb_i;
    logic [LW*N-1:0] s_len_i;
    logic [DW-1:0]   s_rdata_o, fp_s_rdata_o;
    logic            m_wvalid_o, fp_m_wvalid_o;
    logic [AW-1:0]   m_waddr_o, fp_m_waddr_o;
    logic [DW-1:0]   m_wdata_o, fp_m_wdata_o;
    logic [TW-1:0]   m_wstrb_o, fp_m_wstrb_o;
    logic [LW-1:0]   m_wlen_o, fp_m_wlen_o;
    logic            m_wready_i, m_wlast_i;
    logic            m_rvalid_o, fp_m_rvalid_o;
    logic [AW-1:0]   m_raddr_o, fp_m_raddr_o;
    logic [LW-1:0]   m_rlen_o, fp_m_rlen_o;
    logic            m_rready_i, m_rlast_i;
    logic [DW-1:0]   m_rdata_i;
    logic            w_busy_o, r_busy_o, fp_w_busy_o, fp_r_busy_o;
    logic [SW-1:0]   w_grant_o, r_grant_o, fp_w_grant_o, fp_r_grant_o;
    logic [1:0]      len_err_o, fp_len_err_o;
    logic            err_clr_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    xmerge_rr #(.ADDR_W(AW), .DATA_W(DW), .N_SLAVES(N), .LEN_W(LW), .ARB_RR(1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .s_last_o(s_last_o), .s_addr_i(s_addr_i), .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i),
        .s_len_i(s_len_i), .s_rdata_o(s_rdata_o), .m_wvalid_o(m_wvalid_o), .m_waddr_o(m_waddr_o),
        .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wlen_o(m_wlen_o), .m_wready_i(m_wready_i),
        .m_wlast_i(m_wlast_i), .m_rvalid_o(m_rvalid_o), .m_raddr_o(m_raddr_o), .m_rlen_o(m_rlen_o),
        .m_rready_i(m_rready_i), .m_rlast_i(m_rlast_i), .m_rdata_i(m_rdata_i), .w_busy_o(w_busy_o),
        .r_busy_o(r_busy_o), .w_grant_o(w_grant_o), .r_grant_o(r_grant_o), .len_err_o(len_err_o),
        .err_clr_i(err_clr_i)
    );

    xmerge_rr #(.ADDR_W(AW), .DATA_W(DW), .N_SLAVES(N), .LEN_W(LW), .ARB_RR(0)) dut_fp (
        .clk_i(clk_i), .rst_ni(rst_ni), .s_valid_i(s_valid_i), .s_ready_o(fp_s_ready_o),
        .s_last_o(fp_s_last_o), .s_addr_i(s_addr_i), .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i),
        .s_len_i(s_len_i), .s_rdata_o(fp_s_rdata_o), .m_wvalid_o(fp_m_wvalid_o), .m_waddr_o(fp_m_waddr_o),
        .m_wdata_o(fp_m_wdata_o), .m_wstrb_o(fp_m_wstrb_o), .m_wlen_o(fp_m_wlen_o), .m_wready_i(m_wready_i),
        .m_wlast_i(m_wlast_i), .m_rvalid_o(fp_m_rvalid_o), .m_raddr_o(fp_m_raddr_o), .m_rlen_o(fp_m_rlen_o),
        .m_rready_i(m_rready_i), .m_rlast_i(m_rlast_i), .m_rdata_i(m_rdata_i), .w_busy_o(fp_w_busy_o),
        .r_busy_o(fp_r_busy_o), .w_grant_o(fp_w_grant_o), .r_grant_o(fp_r_grant_o), .len_err_o(fp_len_err_o),
        .err_clr_i(err_clr_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_slave(input int g, input logic v, input logic [TW-1:0] strb, input logic [LW-1:0] len);
        s_valid_i[g]          = v;
        s_wstrb_i[g*TW +: TW] = strb;
        s_len_i[g*LW +: LW]   = len;
    endtask

    task automatic clear_inputs();
        s_valid_i  = '0;
        s_wstrb_i  = '0;
        s_len_i    = '0;
        m_wready_i = 1'b0;
        m_wlast_i  = 1'b0;
        m_rready_i = 1'b0;
        m_rlast_i  = 1'b0;
        m_rdata_i  = '0;
        err_clr_i  = 1'b0;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [SW-1:0] rr_exp [4];
        rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd3; rr_exp[3] = 2'd0;
        for (int g = 0; g < N; g++) begin
            s_addr_i[g*AW +: AW]  = 32'hA000_0000 + 32'(g);
            s_wdata_i[g*DW +: DW] = 32'hD000_0000 + 32'(g);
        end
        apply_reset();
        #1;
        chk("rst_w_busy", w_busy_o, 64'd0);
        chk("rst_r_busy", r_busy_o, 64'd0);
        chk("rst_len_err", len_err_o, 64'd0);
        chk("rst_s_ready", s_ready_o, 64'd0);

        // Single write: slave 2, len 3, last on the 4th beat.
        set_slave(2, 1'b1, 4'hF, 8'd3);
        m_wready_i = 1'b1;
        #1;
        chk("w1_idle_busy", w_busy_o, 64'd0);
        tick();
        for (int b = 0; b < 4; b++) begin
            m_wlast_i = (b == 3);
            #1;
            chk("w1_grant", w_grant_o, 64'd2);
            chk("w1_wvalid", m_wvalid_o, 64'd1);
            chk("w1_ready", s_ready_o, 64'h4);
            chk("w1_last", s_last_o, (b == 3) ? 64'h4 : 64'h0);
            if (b == 0) begin
                chk("w1_addr", m_waddr_o, 64'hA000_0002);
                chk("w1_wdata", m_wdata_o, 64'hD000_0002);
                chk("w1_wlen", m_wlen_o, 64'd3);
            end
            tick();
        end
        set_slave(2, 1'b0, 4'h0, 8'd0);
        m_wlast_i = 1'b0;
        #1;
        chk("w1_end_busy", w_busy_o, 64'd0);
        chk("w1_end_err", len_err_o, 64'd0);
        chk("w1_end_grant", w_grant_o, 64'd0);

        // Round-robin vs fixed priority: slaves 0,1,3 write with len 0.
        apply_reset();
        set_slave(0, 1'b1, 4'hF, 8'd0);
        set_slave(1, 1'b1, 4'hF, 8'd0);
        set_slave(3, 1'b1, 4'hF, 8'd0);
        m_wready_i = 1'b1;
        m_wlast_i  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_busy", w_busy_o, 64'd1);
            chk("rr_grant", w_grant_o, 64'(rr_exp[k]));
            chk("fp_grant", fp_w_grant_o, 64'd0);
            chk("fp_busy", fp_w_busy_o, 64'd1);
            tick();
            chk("rr_bubble", w_busy_o, 64'd0);
            chk("fp_bubble", fp_w_busy_o, 64'd0);
        end

        // Concurrent: slave 1 writes (len 1), slave 2 reads (len 2).
        apply_reset();
        set_slave(1, 1'b1, 4'h3, 8'd1);
        set_slave(2, 1'b1, 4'h0, 8'd2);
        m_wready_i = 1'b1;
        m_rready_i = 1'b1;
        m_rdata_i  = 32'hCAFE_0001;
        tick();
        chk("cc_w_grant", w_grant_o, 64'd1);
        chk("cc_r_grant", r_grant_o, 64'd2);
        chk("cc_r_valid", m_rvalid_o, 64'd1);
        chk("cc_ready", s_ready_o, 64'h6);
        chk("cc_rdata", s_rdata_o, 64'hCAFE_0001);
        chk("cc_raddr", m_raddr_o, 64'hA000_0002);
        chk("cc_wdata", m_wdata_o, 64'hD000_0001);
        chk("cc_wstrb", m_wstrb_o, 64'h3);
        chk("cc_rlen", m_rlen_o, 64'd2);
        tick();
        m_wlast_i = 1'b1;
        #1;
        chk("cc_wlast", s_last_o, 64'h2);
        tick();
        set_slave(1, 1'b0, 4'h0, 8'd0);
        m_wlast_i = 1'b0;
        m_rlast_i = 1'b1;
        #1;
        chk("cc_w_done", w_busy_o, 64'd0);
        chk("cc_r_busy", r_busy_o, 64'd1);
        chk("cc_rlast", s_last_o, 64'h4);
        chk("cc_r_ready", s_ready_o, 64'h4);
        tick();
        set_slave(2, 1'b0, 4'h0, 8'd0);
        m_rlast_i = 1'b0;
        #1;
        chk("cc_r_done", r_busy_o, 64'd0);
        chk("cc_err", len_err_o, 64'd0);

        // Length mismatch: read len 3 ended by master last on beat 2.
        apply_reset();
        set_slave(0, 1'b1, 4'h0, 8'd3);
        m_rready_i = 1'b1;
        tick();
        chk("lm_grant", r_busy_o, 64'd1);
        tick();
        m_rlast_i = 1'b1;
        #1;
        chk("lm_last", s_last_o, 64'h1);
        tick();
        set_slave(0, 1'b0, 4'h0, 8'd0);
        m_rlast_i = 1'b0;
        #1;
        chk("lm_done", r_busy_o, 64'd0);
        chk("lm_err", len_err_o, 64'h2);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("lm_clr", len_err_o, 64'h0);

        // Reset mid-burst after beat 2 of 4, then pointer must restart at 0.
        apply_reset();
        set_slave(1, 1'b1, 4'hF, 8'd3);
        m_wready_i = 1'b1;
        tick();
        chk("mr_grant", w_grant_o, 64'd1);
        tick();
        tick();
        rst_ni = 1'b0;
        #1;
        chk("mr_busy", w_busy_o, 64'd0);
        chk("mr_grant0", w_grant_o, 64'd0);
        chk("mr_wvalid", m_wvalid_o, 64'd0);
        chk("mr_waddr", m_waddr_o, 64'd0);
        chk("mr_wdata", m_wdata_o, 64'd0);
        chk("mr_wlen", m_wlen_o, 64'd0);
        chk("mr_ready", s_ready_o, 64'd0);
        chk("mr_last", s_last_o, 64'd0);
        set_slave(1, 1'b0, 4'h0, 8'd0);
        tick();
        rst_ni = 1'b1;
        set_slave(0, 1'b1, 4'hF, 8'd0);
        set_slave(2, 1'b1, 4'hF, 8'd0);
        #1;
        chk("mr_idle", w_busy_o, 64'd0);
        tick();
        chk("mr_new_busy", w_busy_o, 64'd1);
        chk("mr_new_grant", w_grant_o, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
